// File: rtl/uart_avm_link_if.sv
// Avalon-MM bundle between uart_avm_link (master) and a UART core (slave).
// Signal names keep the link's original port names.
interface uart_avm_link_if;
  logic [4:0]  o_address;
  logic        o_read;
  logic        o_write;
  logic [31:0] o_writedata;
  logic [31:0] i_readdata;
  logic        i_waitrequest;

  modport master (
    output o_address, o_read, o_write, o_writedata,
    input  i_readdata, i_waitrequest
  );

  modport slave (
    input  o_address, o_read, o_write, o_writedata,
    output i_readdata, i_waitrequest
  );
endinterface

// File: rtl/uart_avm_link.sv
// Full-duplex bridge between byte streams and an Avalon-MM UART core:
// a TX FIFO drains to the data register, RX bytes are packed into BYTES-wide words.
module uart_avm_link #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned BYTES = 2,
  parameter int unsigned LW    = $clog2(DEPTH) + 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  uart_avm_link_if.master      avm,
  input  logic                 i_tx_valid,
  input  logic [7:0]           i_tx_data,
  output logic                 o_tx_ready,
  output logic [LW-1:0]        o_tx_level,
  output logic                 o_rx_valid,
  output logic [8*BYTES-1:0]   o_rx_data,
  input  logic                 i_rx_ready
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned KW = (BYTES > 1) ? $clog2(BYTES) : 1;

  localparam logic [4:0] ADDR_RX   = 5'd0;
  localparam logic [4:0] ADDR_TX   = 5'd4;
  localparam logic [4:0] ADDR_STAT = 5'd8;

  typedef enum logic [1:0] {IDLE, STAT, RXRD, TXWR} state_t;

  state_t        state;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [KW-1:0] k;
  logic          prio;

  logic done;
  logic push;
  logic pop;
  logic tx_nempty;
  logic rx_ok;
  logic tx_ok;

  assign done       = (avm.o_read | avm.o_write) & ~avm.i_waitrequest;
  assign tx_nempty  = (o_tx_level != '0);
  assign o_tx_ready = (o_tx_level < LW'(DEPTH));
  assign push       = i_tx_valid & o_tx_ready;
  assign pop        = (state == TXWR) & done;
  assign rx_ok      = avm.i_readdata[7] & ~o_rx_valid;
  assign tx_ok      = avm.i_readdata[6] & tx_nempty;

  // Head only moves on pop, so write data stays stable through a stalled TXWR.
  assign avm.o_writedata = {24'b0, mem[rd_ptr]};

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= i_tx_data;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state         <= IDLE;
      avm.o_read    <= 1'b0;
      avm.o_write   <= 1'b0;
      avm.o_address <= ADDR_STAT;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      o_tx_level    <= '0;
      k             <= '0;
      prio          <= 1'b0;
      o_rx_valid    <= 1'b0;
      o_rx_data     <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      o_tx_level <= o_tx_level + LW'(1);
      else if (pop && !push) o_tx_level <= o_tx_level - LW'(1);

      if (o_rx_valid && i_rx_ready) o_rx_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (tx_nempty || !o_rx_valid) begin
            state         <= STAT;
            avm.o_read    <= 1'b1;
            avm.o_address <= ADDR_STAT;
          end
        end

        STAT: begin
          if (done) begin
            // Round-robin only when both directions are ready.
            if (rx_ok && tx_ok) prio <= ~prio;
            if (rx_ok && (!tx_ok || !prio)) begin
              state         <= RXRD;
              avm.o_address <= ADDR_RX;
            end else if (tx_ok) begin
              state         <= TXWR;
              avm.o_read    <= 1'b0;
              avm.o_write   <= 1'b1;
              avm.o_address <= ADDR_TX;
            end else begin
              state         <= IDLE;
              avm.o_read    <= 1'b0;
              avm.o_address <= ADDR_STAT;
            end
          end
        end

        RXRD: begin
          if (done) begin
            o_rx_data[8*k +: 8] <= avm.i_readdata[7:0];
            if (k == KW'(BYTES - 1)) begin
              k          <= '0;
              o_rx_valid <= 1'b1;
            end else begin
              k <= k + KW'(1);
            end
            state         <= IDLE;
            avm.o_read    <= 1'b0;
            avm.o_address <= ADDR_STAT;
          end
        end

        TXWR: begin
          if (done) begin
            state         <= IDLE;
            avm.o_write   <= 1'b0;
            avm.o_address <= ADDR_STAT;
          end
        end

        default: begin
          state         <= IDLE;
          avm.o_read    <= 1'b0;
          avm.o_write   <= 1'b0;
          avm.o_address <= ADDR_STAT;
        end
      endcase
    end
  end

endmodule
